db_operand_reader: RTL

- Read-side sequencer for the data-bank register file: owns both bank read ports (A and B) and streams operand pairs out to the arithmetic datapath.
- On a start command it walks two address sequences in lockstep, base_a.. and base_b.., for count pairs.
- Each pair is captured into an output register and presented on a valid/ready stream with backpressure, at up to one pair per cycle.
- Sits between the data bank and the MAC/divider units of the filter core.

---
 rtl/db_operand_reader.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/db_operand_reader.sv
// Read-side sequencer for the data bank: walks two bank addresses in lockstep
// and streams the captured operand pairs out on a valid/ready interface.
//
// state | meaning
// IDLE  | waiting for start; a zero-count start pulses done and stays here
// RUN   | addresses walking, pairs captured whenever the output slot is free
// DRAIN | last pair captured, waiting for the consumer to accept it
module db_operand_reader #(
    parameter int W     = 24,
    parameter int DEPTH = 40,
    parameter int ADDRW = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ADDRW-1:0] base_a,
    input  logic [ADDRW-1:0] base_b,
    input  logic [ADDRW:0]   count,
    output logic             busy,
    output logic             done,
    output logic [ADDRW-1:0] db_raddr_a,
    output logic [ADDRW-1:0] db_raddr_b,
    input  logic [W-1:0]     db_rdata_a,
    input  logic [W-1:0]     db_rdata_b,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [W-1:0]     op_a,
    output logic [W-1:0]     op_b,
    output logic             op_last
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(DEPTH - 1);
    localparam logic [ADDRW-1:0] ADDR_ONE  = ADDRW'(1);
    localparam logic [ADDRW:0]   CNT_ONE   = (ADDRW + 1)'(1);

    state_t           state_q, state_nxt;
    logic [ADDRW-1:0] raddr_a_q, raddr_a_nxt;
    logic [ADDRW-1:0] raddr_b_q, raddr_b_nxt;
    logic [ADDRW:0]   remaining_q, remaining_nxt;
    logic             op_valid_q, op_valid_nxt;
    logic             op_last_q, op_last_nxt;
    logic [W-1:0]     op_a_q, op_a_nxt;
    logic [W-1:0]     op_b_q, op_b_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic             cap;
    logic             last_pair;

    // Out-of-range addresses also fold back to 0 so an illegal base cannot
    // walk past the bank forever.
    function automatic logic [ADDRW-1:0] next_addr(input logic [ADDRW-1:0] a);
        return (a >= LAST_ADDR) ? '0 : a + ADDR_ONE;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            raddr_a_q   <= '0;
            raddr_b_q   <= '0;
            remaining_q <= '0;
            op_valid_q  <= 1'b0;
            op_last_q   <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            raddr_a_q   <= raddr_a_nxt;
            raddr_b_q   <= raddr_b_nxt;
            remaining_q <= remaining_nxt;
            op_valid_q  <= op_valid_nxt;
            op_last_q   <= op_last_nxt;
            op_a_q      <= op_a_nxt;
            op_b_q      <= op_b_nxt;
            busy_q      <= busy_nxt;
            done_q      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state_q;
        raddr_a_nxt   = raddr_a_q;
        raddr_b_nxt   = raddr_b_q;
        remaining_nxt = remaining_q;
        op_valid_nxt  = op_valid_q;
        op_last_nxt   = op_last_q;
        op_a_nxt      = op_a_q;
        op_b_nxt      = op_b_q;
        busy_nxt      = busy_q;
        done_nxt      = 1'b0;
        cap           = !op_valid_q || op_ready;
        // <=1 rather than ==1 so a corrupted counter still ends the command
        last_pair     = (remaining_q <= CNT_ONE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        raddr_a_nxt   = base_a;
                        raddr_b_nxt   = base_b;
                        remaining_nxt = count;
                        busy_nxt      = 1'b1;
                        state_nxt     = S_RUN;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (cap) begin
                    op_a_nxt     = db_rdata_a;
                    op_b_nxt     = db_rdata_b;
                    op_valid_nxt = 1'b1;
                    op_last_nxt  = last_pair;
                    raddr_a_nxt  = next_addr(raddr_a_q);
                    raddr_b_nxt  = next_addr(raddr_b_q);
                    if (remaining_q != '0) begin
                        remaining_nxt = remaining_q - CNT_ONE;
                    end
                    if (last_pair) begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (op_ready) begin
                    op_valid_nxt = 1'b0;
                    op_last_nxt  = 1'b0;
                    done_nxt     = 1'b1;
                    busy_nxt     = 1'b0;
                    state_nxt    = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign db_raddr_a = raddr_a_q;
    assign db_raddr_b = raddr_b_q;
    assign op_valid   = op_valid_q;
    assign op_last    = op_last_q;
    assign op_a       = op_a_q;
    assign op_b       = op_b_q;

endmodule
